// File: rtl/s3_pkg.sv
// Shared constants and types for the S3 polynomial unpacker.
// A packed polynomial is 140 bytes. Each byte carries five ternary digits.
package s3_pkg;
    localparam int S3_BYTES       = 140;
    localparam int S3_WORDS       = S3_BYTES / 2;
    localparam int TRITS_PER_BYTE = 5;
    localparam int TRIT_W         = 2;
    localparam int NUM_LANES      = 2;
    localparam logic [7:0] BYTE_MAX = 8'd242;

    typedef logic [TRIT_W-1:0] trit_t;

    typedef enum logic [2:0] {IDLE, LOAD, DIV, OUT, DONE} unpack_state_t;
endpackage

// File: rtl/unpack_s3_if.sv
// Byte-word input stream and trit-word output stream of the S3 unpacker.
interface unpack_s3_if;
    import s3_pkg::*;

    logic                                       in_valid;
    logic                                       in_ready;
    logic [NUM_LANES*8-1:0]                     in_data;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [NUM_LANES*TRITS_PER_BYTE*TRIT_W-1:0] out_trits;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_trits);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_trits);
endinterface

// File: rtl/byte_to_trit5.sv
// Iterative base-3 splitter for one byte. It produces one trit per step, least significant first.
// A byte above 242 is flagged, and its trit slots stay zero.
module byte_to_trit5
    import s3_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        step,
    input  logic [7:0]                  data,
    output trit_t [TRITS_PER_BYTE-1:0]  trits,
    output logic                        invalid
);
    logic [7:0]  b;
    logic [2:0]  d;
    logic [15:0] prod;
    logic [7:0]  q;
    trit_t       r;

    // Multiplying by 171 and shifting right by 9 equals floor(b/3) for every 8-bit b.
    assign prod = {8'd0, b} * 16'd171;
    assign q    = 8'(prod >> 9);
    // The remainder is 0..2, so only the low two bits of b - 3q are needed.
    assign r    = b[1:0] - 2'(q[1:0] * 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            b       <= '0;
            d       <= '0;
            trits   <= '0;
            invalid <= 1'b0;
        end else if (load) begin
            b       <= data;
            d       <= '0;
            trits   <= '0;
            invalid <= (data > BYTE_MAX);
        end else if (step) begin
            b <= q;
            d <= d + 3'd1;
            if (!invalid) begin
                for (int i = 0; i < TRITS_PER_BYTE; i++)
                    if (d == 3'(i)) trits[i] <= r;
            end
        end
    end
endmodule

// File: rtl/unpack_s3.sv
// S3 unpacker top level. It takes one 16-bit word (two bytes) per transfer and returns ten trits.
// The top holds the word sequencing, the handshakes and the sticky range error.
module unpack_s3
    import s3_pkg::*;
#(
    parameter int N_WORDS = S3_WORDS
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    unpack_s3_if.slave   bus,
    output logic         done,
    output logic         err
);
    localparam int CW = $clog2(N_WORDS + 1);

    unpack_state_t state, state_nxt;
    logic [CW-1:0] word_cnt;
    logic [2:0]    div_cnt;
    logic          load, step;

    trit_t [NUM_LANES-1:0][TRITS_PER_BYTE-1:0] lane_trits;
    logic  [NUM_LANES-1:0]                     lane_inv;

    genvar l;
    generate
        for (l = 0; l < NUM_LANES; l++) begin : g_lane
            byte_to_trit5 u_b2t (
                .clk     (clk),
                .rst     (rst),
                .load    (load),
                .step    (step),
                .data    (bus.in_data[8*l +: 8]),
                .trits   (lane_trits[l]),
                .invalid (lane_inv[l])
            );
        end
    endgenerate

    // Both lanes hold their trits from the end of DIV until the next load, so the output stays stable under backpressure.
    assign bus.out_trits = lane_trits;

    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        step          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load      = 1'b1;
                    state_nxt = DIV;
                end
            end
            DIV: begin
                step = 1'b1;
                if (div_cnt == 3'(TRITS_PER_BYTE - 1)) state_nxt = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_nxt = (word_cnt == CW'(N_WORDS - 1)) ? DONE : LOAD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            div_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= (state == DIV) ? div_cnt + 3'd1 : 3'd0;
            if (state == IDLE && start) begin
                word_cnt <= '0;
                err      <= 1'b0;
            end else begin
                if (state == OUT && bus.out_ready) word_cnt <= word_cnt + CW'(1);
                if (state == DIV && |lane_inv)     err      <= 1'b1;
            end
        end
    end
endmodule

// File: doc/unpack_s3.md
# unpack_s3

Streaming decoder for packed S3 polynomials: accepts 16-bit words holding two packed bytes, each byte encoding five ternary coefficients as sum t_i·3^i, and emits 20-bit trit words of ten 2-bit trits. It is the inverse of the S3 packer and sits on the decapsulation side, between the ciphertext/byte buffer and the S3 arithmetic units. One packed polynomial is 140 bytes = 70 words = 700 trits; coefficient 700 is not carried and is zero by definition.

## Interface
- `N_WORDS`, 70: 16-bit words per polynomial.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a polynomial; honoured only in IDLE.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts `in_data`.
- `in_data`  in  16  `[7:0]` is byte 2k, `[15:8]` is byte 2k+1.
- `out_valid`  out  1  `out_trits` valid.
- `out_ready`  in  1  consumer accepts `out_trits`.
- `out_trits`  out  20  trits 0–4 of the low byte in `[9:0]`, trits of the high byte in `[19:10]`; trit i of a byte sits at `[2i+1:2i]` of its 10-bit half, encoded 0/1/2.
- `done`  out  1  one-cycle pulse after the last word is delivered.
- `err`  out  1  sticky; set when any byte ≥ 243; cleared by `rst` or an accepted `start`.

## Operation
- FSM states: IDLE, LOAD, DIV, OUT, DONE.
- IDLE: if `start`, clear the word counter and `err`, then go to LOAD.
- LOAD: `in_ready`=1. On `in_valid&in_ready`, latch both bytes and go to DIV with digit counter 0.
- DIV: runs exactly 5 cycles. Each cycle, both bytes in parallel: r = b − 3q with q = (b·171)>>9, which is exact for b ≤ 255. Write r into trit slot d and set b ← q.
- OUT: `out_valid`=1 and `out_trits` holds stable until `out_ready`. After the handshake, increment the word counter. If the counter reaches `N_WORDS`, go to DONE; otherwise go to LOAD.
- DONE: assert `done` for one cycle, then go to IDLE.
- Invalid byte (≥ 243):
  - set `err`;
  - force all five trits of that byte to 0;
  - leave the other byte of the word unaffected;
  - continue processing normally.
- `start` outside IDLE is ignored. `in_valid` outside LOAD is ignored and the data is not consumed.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_trits`=0, `done`=0, `err`=0; state IDLE, counters 0.
- `start` sampled in cycle T gives `in_ready`=1 in cycle T+1.
- Input handshake in cycle T:
  - DIV in cycles T+1..T+5;
  - `out_valid`=1 from cycle T+6.
- Output handshake in cycle U:
  - if not last, `in_ready`=1 in U+1;
  - if last, `done`=1 in U+1, and the block is in IDLE in U+2.
- Minimum 7 cycles per word; 490 cycles per polynomial with no stalls.
- Backpressure: while `out_ready`=0, `out_trits` and `out_valid` must not change.
- `rst` at any cycle, including mid-DIV or mid-OUT, returns the block to reset values next cycle. No partial word is emitted afterwards.

## Structure
- Package `s3_pkg`:
  - `S3_BYTES`=140, `S3_WORDS`=70, `TRITS_PER_BYTE`=5, `TRIT_W`=2;
  - `typedef logic [1:0] trit_t`;
  - FSM state enum `unpack_state_t`.
- Sub-module `byte_to_trit5`: one 8-bit iterative divider.
  - Inputs: load, step, byte.
  - Outputs: five trit registers, invalid flag.
  - Instantiated twice, once per byte lane; the top holds the FSM, counters and handshakes.

## Test plan
- Reset, then idle with `in_valid`=1 and no `start` -> `in_ready`=0, no `out_valid`, all outputs 0.
- `start`, then word 0x0000 -> `out_trits`=0x00000 at T+6, `err`=0.
- Word 0x51F2 (high byte 81, low byte 242) -> `[9:0]`=10'b1010101010 and `[19:10]`=10'b0100000000, i.e. `out_trits`=0x402AA.
- Word 0x01F3 -> `err`=1 (sticky), low half 0, high half trit0=1, so `out_trits`=0x00400.
- Full 70-word run with random `in_valid` gaps and `out_ready` stalls -> 70 outputs matching a reference unpack, `out_trits` stable during stalls, single `done` pulse one cycle after the 70th output handshake.
- `rst` asserted during DIV of word 5, then a new `start` -> no stale output; the new run's first output corresponds to its first input word.
